pipe_ctrl_tracker: RTL
======================

PIPE_CTRL_TRACKER -- requirements
Module: pipe_ctrl_tracker

Interface
REQ-001 SHALL have ports: clock  in  1  rising-edge system clock.
REQ-002 SHALL have ports: resetn  in  1  asynchronous reset, active-low.
REQ-003 SHALL have ports: wreg, m2reg, wmem, jal, j, beq, bne  in  1 each  ID-stage decoded controls from pipeidcu.
REQ-004 SHALL have ports: aluc  in  5  ID ALU control; rn  in  5  ID destination after regrt mux.
REQ-005 SHALL have ports: we_pc_ir  in  1  0 = ID stall; reset_ir  in  1  1 = ID instruction squashed.
REQ-006 SHALL have ports: ewreg, em2reg, ewmem, ejal  out  1 each; ealuc  out  5; ern  out  5  EX-stage controls.
REQ-007 SHALL have ports: ex_is_cond, ex_is_uncond  out  1  EX holds branch / jump.
REQ-008 SHALL have ports: mwreg, mm2reg, mwmem  out  1 each; mrn  out  5; mem_is_cond  out  1  MEM-stage controls.

Function
REQ-009 SHALL advance EX->MEM on every clock edge; no MEM stall.
REQ-010 SHALL load EX from ID each edge when we_pc_ir=1 and reset_ir=0; latency ID->EX 1 cycle, ID->MEM 2 cycles.
REQ-011 SHALL load a bubble into EX when we_pc_ir=0 or reset_ir=1: all EX 1-bit outputs 0, ealuc 0, ern 0.
REQ-012 SHALL treat simultaneous stall and squash as one bubble.
REQ-013 SHALL latch ern = 31 when jal=1, else rn.
REQ-014 SHALL force ewreg=0 and ern=0 when the latched destination is 0; register $0 never reported as a hazard source.
REQ-015 SHALL force ern=0 when wreg=0.
REQ-016 SHALL set ex_is_cond = beq|bne and ex_is_uncond = j|jal of the latched instruction; both 0 for a bubble.
REQ-017 SHALL copy ewreg, em2reg, ewmem, ern, ex_is_cond into mwreg, mm2reg, mwmem, mrn, mem_is_cond each edge.
REQ-018 SHALL keep em2reg=1 only with ewreg=1; a load to $0 yields em2reg=0.
REQ-019 SHALL drive all outputs directly from flops, no combinational ID->output path.

Reset
REQ-020 SHALL clear every EX and MEM register to 0 immediately on resetn=0, independent of clock.
REQ-021 SHALL, on resetn deassertion mid-stream, resume at the first rising edge with EX and MEM holding bubbles.

Configuration
REQ-022 SHALL, with PIPE_PERF_CNT_EN defined, add ports stall_cnt and flush_cnt (out, 16 each).
REQ-023 SHALL, with PIPE_PERF_CNT_EN, increment flush_cnt per edge with reset_ir=1, else stall_cnt per edge with we_pc_ir=0.
REQ-024 SHALL saturate both counters at 16'hFFFF and clear them on resetn=0.
REQ-025 SHALL, without PIPE_PERF_CNT_EN, omit both ports and counters; other behaviour identical.

Structure
REQ-026 SHALL place REG_ZERO=5'd0, REG_RA=5'd31, ALUC_NOP=5'd0 and the counter width (16) in shared package pipe_ctrl_pkg.
REQ-027 SHALL implement counters as sub-module pipe_sat_cnt (enable, saturating), instantiated twice under PIPE_PERF_CNT_EN.

Verification
REQ-028 SHALL cover: after resetn low then high, add rn=5, wreg=1 -> next edge ewreg=1, ern=5; following edge mwreg=1, mrn=5.
REQ-029 SHALL cover: lw rn=3, m2reg=1, we_pc_ir=0 -> EX bubble (ewreg=0, ern=0); MEM receives the previous EX contents.
REQ-030 SHALL cover: jal=1, rn=0 -> ern=31, ewreg=1, ex_is_uncond=1; beq=1, wreg=0 -> ex_is_cond=1, ern=0, then mem_is_cond=1.
REQ-031 SHALL cover: wreg=1, rn=0 -> ewreg=0, ern=0; stall plus reset_ir together -> single bubble, flush_cnt+1, stall_cnt unchanged.
REQ-032 SHALL cover: resetn pulsed low between edges with ewreg=1 -> all outputs 0 within the same cycle.
REQ-033 SHALL cover: 65540 stall cycles -> stall_cnt = 16'hFFFF (PIPE_PERF_CNT_EN defined).

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants, stage-control structs and the ID->EX control decode.
// Latency: n/a (package).  Backpressure: n/a (package).
// Holds register-number constants, the ALU no-op code and the perf counter width.
package pipe_ctrl_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;
  localparam logic [4:0] ALUC_NOP = 5'd0;
  localparam int         CNT_W    = 16;

  // Controls latched into the EX stage.
  typedef struct packed {
    logic       wreg;
    logic       m2reg;
    logic       wmem;
    logic       jal;
    logic [4:0] aluc;
    logic [4:0] rn;
    logic       is_cond;
    logic       is_uncond;
  } ex_ctrl_t;

  // Controls carried on into the MEM stage.
  typedef struct packed {
    logic       wreg;
    logic       m2reg;
    logic       wmem;
    logic [4:0] rn;
    logic       is_cond;
  } mem_ctrl_t;

  localparam ex_ctrl_t EX_BUBBLE = '{
    wreg: 1'b0, m2reg: 1'b0, wmem: 1'b0, jal: 1'b0,
    aluc: ALUC_NOP, rn: REG_ZERO, is_cond: 1'b0, is_uncond: 1'b0
  };

  // Canonicalise ID controls: jal writes $ra, a write to $0 is dropped
  // entirely (so $0 never looks like a hazard source), a non-writing
  // instruction reports destination 0, and a load only keeps m2reg if
  // it actually writes.
  function automatic ex_ctrl_t ex_decode(
    input logic       wreg,
    input logic       m2reg,
    input logic       wmem,
    input logic       jal,
    input logic       j,
    input logic       beq,
    input logic       bne,
    input logic [4:0] aluc,
    input logic [4:0] rn
  );
    ex_ctrl_t   e;
    logic [4:0] dest;
    logic       wr;
    dest        = jal ? REG_RA : rn;
    wr          = wreg && (dest != REG_ZERO);
    e.wreg      = wr;
    e.m2reg     = m2reg && wr;
    e.wmem      = wmem;
    e.jal       = jal;
    e.aluc      = aluc;
    e.rn        = wr ? dest : REG_ZERO;
    e.is_cond   = beq | bne;
    e.is_uncond = j | jal;
    return e;
  endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating event counter: counts clock edges with en=1, sticks at all-ones.
// Latency: count visible 1 cycle after the enabled edge.  Backpressure: none.
// Ports: clock, resetn (async, active-low clear), en (count this edge), cnt (value).
module pipe_sat_cnt
  import pipe_ctrl_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (en && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl_tracker.sv
// Tracks decoded pipeline controls from ID through EX and MEM for hazard/forwarding logic.
// Latency: ID->EX 1 cycle, ID->MEM 2 cycles; all outputs come straight from flops.
// Backpressure: ID stall (we_pc_ir=0) or squash (reset_ir=1) loads a bubble into EX; MEM never stalls.
// Ports: clock, resetn (async, active-low); ID controls wreg/m2reg/wmem/jal/j/beq/bne,
//   aluc, rn, we_pc_ir, reset_ir; EX outputs ewreg/em2reg/ewmem/ejal/ealuc/ern,
//   ex_is_cond/ex_is_uncond; MEM outputs mwreg/mm2reg/mwmem/mrn/mem_is_cond.
// Build option PIPE_PERF_CNT_EN adds stall_cnt/flush_cnt saturating perf counters.
module pipe_ctrl_tracker
  import pipe_ctrl_pkg::*;
(
  input  logic             clock,
  input  logic             resetn,
  input  logic             wreg,
  input  logic             m2reg,
  input  logic             wmem,
  input  logic             jal,
  input  logic             j,
  input  logic             beq,
  input  logic             bne,
  input  logic [4:0]       aluc,
  input  logic [4:0]       rn,
  input  logic             we_pc_ir,
  input  logic             reset_ir,
  output logic             ewreg,
  output logic             em2reg,
  output logic             ewmem,
  output logic             ejal,
  output logic [4:0]       ealuc,
  output logic [4:0]       ern,
  output logic             ex_is_cond,
  output logic             ex_is_uncond,
  output logic             mwreg,
  output logic             mm2reg,
  output logic             mwmem,
  output logic [4:0]       mrn,
  output logic             mem_is_cond
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  ex_ctrl_t  ex_nxt;
  ex_ctrl_t  ex_r;
  mem_ctrl_t mem_r;
  logic      bubble;

  // Stall and squash together still produce exactly one bubble.
  assign bubble = !we_pc_ir || reset_ir;

  always_comb begin
    ex_nxt = EX_BUBBLE;
    if (!bubble) begin
      ex_nxt = ex_decode(wreg, m2reg, wmem, jal, j, beq, bne, aluc, rn);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ex_r  <= EX_BUBBLE;
      mem_r <= '0;
    end else begin
      ex_r  <= ex_nxt;
      mem_r <= '{wreg: ex_r.wreg, m2reg: ex_r.m2reg, wmem: ex_r.wmem,
                 rn: ex_r.rn, is_cond: ex_r.is_cond};
    end
  end

  assign ewreg        = ex_r.wreg;
  assign em2reg       = ex_r.m2reg;
  assign ewmem        = ex_r.wmem;
  assign ejal         = ex_r.jal;
  assign ealuc        = ex_r.aluc;
  assign ern          = ex_r.rn;
  assign ex_is_cond   = ex_r.is_cond;
  assign ex_is_uncond = ex_r.is_uncond;

  assign mwreg        = mem_r.wreg;
  assign mm2reg       = mem_r.m2reg;
  assign mwmem        = mem_r.wmem;
  assign mrn          = mem_r.rn;
  assign mem_is_cond  = mem_r.is_cond;

`ifdef PIPE_PERF_CNT_EN
  // A squash takes precedence: a cycle that is both stalled and squashed
  // counts as a flush only.
  logic flush_en;
  logic stall_en;

  assign flush_en = reset_ir;
  assign stall_en = !we_pc_ir && !reset_ir;

  pipe_sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clock  (clock),
    .resetn (resetn),
    .en     (stall_en),
    .cnt    (stall_cnt)
  );

  pipe_sat_cnt #(.W(CNT_W)) u_flush_cnt (
    .clock  (clock),
    .resetn (resetn),
    .en     (flush_en),
    .cnt    (flush_cnt)
  );
`endif

endmodule
